// File: rtl/fft_pkg.sv
// Shared FFT pipeline definitions: datapath widths, sequencer phase encoding
// and the 8th-root twiddle constants used by the per-stage ROMs.
package fft_pkg;
    localparam int WIDTH = 24;
    localparam int FRAC  = 8;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_STORE = 2'd1,
        ST_BFLY  = 2'd2,
        ST_RSVD  = 2'd3
    } st_e;

    typedef struct packed {
        logic signed [WIDTH-1:0] r;
        logic signed [WIDTH-1:0] i;
    } cplx_t;

    // W8^k in Q(WIDTH-FRAC).FRAC, 1.0 = 256
    localparam cplx_t W8_0 = '{r:  24'sd256, i:  24'sd0};
    localparam cplx_t W8_1 = '{r:  24'sd181, i: -24'sd181};
    localparam cplx_t W8_2 = '{r:  24'sd0,   i: -24'sd256};
    localparam cplx_t W8_3 = '{r: -24'sd181, i: -24'sd181};
endpackage

// File: rtl/sdf_bf_stage_if.sv
// Sample/twiddle input bundle and registered output bundle of one SDF stage.
interface sdf_bf_stage_if #(parameter int WIDTH = fft_pkg::WIDTH);
    logic                    in_valid;
    logic signed [WIDTH-1:0] din_r;
    logic signed [WIDTH-1:0] din_i;
    logic [1:0]              state;
    logic signed [WIDTH-1:0] w_r;
    logic signed [WIDTH-1:0] w_i;
    logic                    out_valid;
    logic signed [WIDTH-1:0] dout_r;
    logic signed [WIDTH-1:0] dout_i;

    modport master (
        output in_valid, din_r, din_i, state, w_r, w_i,
        input  out_valid, dout_r, dout_i
    );
    modport slave (
        input  in_valid, din_r, din_i, state, w_r, w_i,
        output out_valid, dout_r, dout_i
    );
endinterface

// File: rtl/cplx_mult_rnd.sv
// Combinational complex multiply by a Q.FRAC twiddle, round-half-up then
// keep the low WIDTH bits of the rescaled product.
module cplx_mult_rnd #(
    parameter int WIDTH = fft_pkg::WIDTH,
    parameter int FRAC  = fft_pkg::FRAC
) (
    input  logic signed [WIDTH-1:0] a_r_i,
    input  logic signed [WIDTH-1:0] a_i_i,
    input  logic signed [WIDTH-1:0] w_r_i,
    input  logic signed [WIDTH-1:0] w_i_i,
    output logic signed [WIDTH-1:0] p_r_o,
    output logic signed [WIDTH-1:0] p_i_o
);
    localparam int PW = 2*WIDTH + 1;
    typedef logic signed [PW-1:0] prod_t;
    localparam prod_t RND = prod_t'(1 <<< (FRAC-1));

    prod_t ar, ai, wr, wi, pr, pi;

    assign ar = prod_t'(a_r_i);
    assign ai = prod_t'(a_i_i);
    assign wr = prod_t'(w_r_i);
    assign wi = prod_t'(w_i_i);

    assign pr = ar*wr - ai*wi;
    assign pi = ar*wi + ai*wr;

    // Arithmetic shift floors, so adding half an LSB first rounds half-up
    assign p_r_o = WIDTH'((pr + RND) >>> FRAC);
    assign p_i_o = WIDTH'((pi + RND) >>> FRAC);
endmodule

// File: rtl/sdf_bf_stage.sv
// Radix-2 DIF single-path delay-feedback butterfly stage: delay line, butterfly,
// twiddle on the lower branch, registered output.
module sdf_bf_stage #(
    parameter int WIDTH = fft_pkg::WIDTH,
    parameter int DEPTH = 4,
    parameter int FRAC  = fft_pkg::FRAC
) (
    input logic           clk,
    input logic           rst_n,
    sdf_bf_stage_if.slave bus
);
    import fft_pkg::*;

    logic signed [WIDTH-1:0] dl_r_q [DEPTH];
    logic signed [WIDTH-1:0] dl_i_q [DEPTH];
    logic                    primed_q, primed_d;
    logic                    out_valid_q, out_valid_d;
    logic signed [WIDTH-1:0] dout_r_q, dout_r_d, dout_i_q, dout_i_d;

    logic                    push;
    logic signed [WIDTH-1:0] push_r, push_i;
    logic signed [WIDTH-1:0] head_r, head_i;
    logic signed [WIDTH-1:0] diff_r, diff_i, t_r, t_i;
    st_e                     st;

    // Oldest entry sits at the far end of the shift chain
    assign head_r = dl_r_q[DEPTH-1];
    assign head_i = dl_i_q[DEPTH-1];
    assign diff_r = head_r - bus.din_r;
    assign diff_i = head_i - bus.din_i;
    assign st     = st_e'(bus.state);

    cplx_mult_rnd #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mult (
        .a_r_i (diff_r),
        .a_i_i (diff_i),
        .w_r_i (bus.w_r),
        .w_i_i (bus.w_i),
        .p_r_o (t_r),
        .p_i_o (t_i)
    );

    always_comb begin
        push        = 1'b0;
        push_r      = bus.din_r;
        push_i      = bus.din_i;
        dout_r_d    = dout_r_q;
        dout_i_d    = dout_i_q;
        out_valid_d = 1'b0;
        primed_d    = primed_q;
        if (bus.in_valid) begin
            push = 1'b1;
            case (st)
                ST_STORE: begin
                    dout_r_d    = head_r;
                    dout_i_d    = head_i;
                    out_valid_d = primed_q;
                end
                ST_BFLY: begin
                    dout_r_d    = head_r + bus.din_r;
                    dout_i_d    = head_i + bus.din_i;
                    out_valid_d = 1'b1;
                    push_r      = t_r;
                    push_i      = t_i;
                    primed_d    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            primed_q    <= 1'b0;
            out_valid_q <= 1'b0;
            dout_r_q    <= '0;
            dout_i_q    <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                dl_r_q[k] <= '0;
                dl_i_q[k] <= '0;
            end
        end else begin
            primed_q    <= primed_d;
            out_valid_q <= out_valid_d;
            dout_r_q    <= dout_r_d;
            dout_i_q    <= dout_i_d;
            if (push) begin
                dl_r_q[0] <= push_r;
                dl_i_q[0] <= push_i;
                for (int k = 1; k < DEPTH; k++) begin
                    dl_r_q[k] <= dl_r_q[k-1];
                    dl_i_q[k] <= dl_i_q[k-1];
                end
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.dout_r    = dout_r_q;
    assign bus.dout_i    = dout_i_q;
endmodule

// File: tb/tb_sdf_bf_stage.sv
// Directed bench for sdf_bf_stage: queue-based reference model compared every
// cycle, plus hand-computed literal expectations.
module tb_sdf_bf_stage;
    import fft_pkg::*;

    localparam int W = 24;
    localparam int D = 4;

    logic clk;
    logic rst_n;
    sdf_bf_stage_if #(.WIDTH(W)) bus ();

    sdf_bf_stage #(.WIDTH(W), .DEPTH(D), .FRAC(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;

    // reference model state
    longint q_r[$], q_i[$];
    bit     m_primed;
    bit     exp_ov;
    longint exp_dr, exp_di;

    function automatic longint wrapw(input longint v);
        logic [W-1:0] t;
        t = v[W-1:0];
        return longint'($signed(t));
    endfunction

    function automatic longint rnd(input longint p);
        return (p + 128) >>> 8;
    endfunction

    task automatic model_reset();
        q_r.delete(); q_i.delete();
        for (int k = 0; k < D; k++) begin q_r.push_back(0); q_i.push_back(0); end
        m_primed = 0; exp_ov = 0; exp_dr = 0; exp_di = 0;
    endtask

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Drive one cycle at the falling edge, then advance the model at the rising edge
    task automatic step(input bit v, input logic [1:0] st, input longint dr, input longint di,
                        input longint wr, input longint wi);
        longint hr, hi, nr, ni, dfr, dfi;
        @(negedge clk);
        bus.in_valid = v;
        bus.state    = st;
        bus.din_r    = W'(dr);
        bus.din_i    = W'(di);
        bus.w_r      = W'(wr);
        bus.w_i      = W'(wi);
        @(posedge clk);
        if (rst_n && v) begin
            hr = q_r[0]; hi = q_i[0];
            nr = wrapw(dr); ni = wrapw(di);
            if (st == 2'd1) begin
                exp_dr = hr; exp_di = hi; exp_ov = m_primed;
            end else if (st == 2'd2) begin
                exp_dr = wrapw(hr + nr); exp_di = wrapw(hi + ni); exp_ov = 1;
                dfr = wrapw(hr - nr); dfi = wrapw(hi - ni);
                nr = wrapw(rnd(dfr*wr - dfi*wi));
                ni = wrapw(rnd(dfr*wi + dfi*wr));
                m_primed = 1;
            end else begin
                exp_ov = 0;
            end
            void'(q_r.pop_front()); void'(q_i.pop_front());
            q_r.push_back(nr); q_i.push_back(ni);
        end else if (rst_n) begin
            exp_ov = 0;
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc out_valid", longint'(bus.out_valid), longint'(exp_ov));
            chk("cyc dout_r", longint'(bus.dout_r), exp_dr);
            chk("cyc dout_i", longint'(bus.dout_i), exp_di);
        end
    end

    longint tw_r[4] = '{256, 181, 0, -181};
    longint tw_i[4] = '{0, -181, -256, -181};
    longint bf_exp[4] = '{110, 220, 330, 440};
    longint td_r[4] = '{90, 127, 0, -255};
    longint td_i[4] = '{0, -127, -270, -255};

    task automatic butterfly_run(input bit stall);
        for (int k = 0; k < 4; k++) begin
            if (stall && k == 2) begin
                for (int s = 0; s < 3; s++) begin
                    step(0, 2'd2, 0, 0, 0, 0);
                    #1 chk("stall out_valid", longint'(bus.out_valid), 0);
                    chk("stall dout_r hold", longint'(bus.dout_r), 220);
                end
            end
            step(1, 2'd2, 10*(k+1), 0, tw_r[k], tw_i[k]);
            #1;
            chk("bfly out_valid", longint'(bus.out_valid), 1);
            chk("bfly dout_r", longint'(bus.dout_r), bf_exp[k]);
            chk("bfly dout_i", longint'(bus.dout_i), 0);
            chk("model bfly dout_r", exp_dr, bf_exp[k]);
        end
        for (int k = 0; k < 4; k++) begin
            step(1, 2'd1, 100*(k+1), 0, 0, 0);
            #1;
            chk("drain out_valid", longint'(bus.out_valid), 1);
            chk("drain dout_r", longint'(bus.dout_r), td_r[k]);
            chk("drain dout_i", longint'(bus.dout_i), td_i[k]);
            chk("model drain dout_i", exp_di, td_i[k]);
        end
    endtask

    initial begin
        bus.in_valid = 0; bus.state = 0;
        bus.din_r = '0; bus.din_i = '0; bus.w_r = '0; bus.w_i = '0;
        model_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1 chk_en = 1;

        // reset held with traffic present
        for (int k = 0; k < 3; k++) begin
            step(1, 2'd2, 55, 7, 256, 0);
            #1;
            chk("reset out_valid", longint'(bus.out_valid), 0);
            chk("reset dout_r", longint'(bus.dout_r), 0);
        end
        #1 rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step(1, 2'd0, 0, 0, 0, 0);
            #1 chk("fill out_valid", longint'(bus.out_valid), 0);
        end

        // unprimed drain
        for (int k = 0; k < 4; k++) begin
            step(1, 2'd1, 100*(k+1), 0, 0, 0);
            #1 chk("unprimed out_valid", longint'(bus.out_valid), 0);
        end

        butterfly_run(0);
        butterfly_run(1);

        // idle cycle: output must hold
        step(0, 2'd1, 0, 0, 0, 0);
        #1 chk("idle out_valid", longint'(bus.out_valid), 0);
        chk("idle dout_r hold", longint'(bus.dout_r), -255);

        // wrap: fresh reset, head = 1, then 0x7FFFFF in state 2
        rst_n = 1'b0; model_reset();
        #2 rst_n = 1'b1;
        step(1, 2'd0, 1, 0, 0, 0);
        for (int k = 0; k < 3; k++) step(1, 2'd3, 0, 0, 0, 0);
        step(1, 2'd2, 24'h7FFFFF, 0, 256, 0);
        #1;
        chk("wrap dout_r", longint'(bus.dout_r), -8388608);
        chk("model wrap dout_r", exp_dr, -8388608);
        chk("wrap out_valid", longint'(bus.out_valid), 1);

        // async reset mid state 2
        @(negedge clk);
        bus.in_valid = 1; bus.state = 2'd2; bus.din_r = 24'd5;
        #2 rst_n = 1'b0; model_reset();
        #1;
        chk("async rst out_valid", longint'(bus.out_valid), 0);
        chk("async rst dout_r", longint'(bus.dout_r), 0);
        step(0, 2'd0, 0, 0, 0, 0);
        step(0, 2'd0, 0, 0, 0, 0);
        @(negedge clk);
        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
